// File: rtl/memory_arb_pkg.sv
// Shared constants and types for the memory_arb block.
// MEMORY_ARB_OUTREG_EN selects the read latency constant exported here.
package memory_arb_pkg;

  localparam int MAX_PORTS = 8;

  typedef logic [2:0] port_idx_t;

`ifdef MEMORY_ARB_OUTREG_EN
  localparam int RD_LATENCY = 2;
`else
  localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/memory_arb_rr_arbiter.sv
// Round-robin arbiter: the first valid port at or after the pointer wins,
// and the pointer moves to the port after the winner whenever a grant is taken.
module rr_arbiter
  import memory_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [NUM_PORTS-1:0] valid_in,
  input  logic                 advance_in,
  output logic [NUM_PORTS-1:0] grant_out
);

  port_idx_t ptr_r;
  port_idx_t win_idx_s;
  port_idx_t ptr_nxt_s;
  logic      found_s;
  logic      hit_s;

  // Two passes: ports at/after the pointer first, then the wrapped-around ports.
  always_comb begin
    grant_out = '0;
    win_idx_s = '0;
    found_s   = 1'b0;
    hit_s     = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit_s        = !found_s && valid_in[i] && (port_idx_t'(i) >= ptr_r);
      grant_out[i] = grant_out[i] | hit_s;
      win_idx_s    = hit_s ? port_idx_t'(i) : win_idx_s;
      found_s      = found_s | hit_s;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit_s        = !found_s && valid_in[i] && (port_idx_t'(i) < ptr_r);
      grant_out[i] = grant_out[i] | hit_s;
      win_idx_s    = hit_s ? port_idx_t'(i) : win_idx_s;
      found_s      = found_s | hit_s;
    end
    grant_out = grant_out & {NUM_PORTS{~rst_in}};
    ptr_nxt_s = (win_idx_s == port_idx_t'(NUM_PORTS - 1)) ? 3'd0 : (win_idx_s + 3'd1);
  end

  // Pointer register, advanced only when a grant is consumed.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr_r <= 3'd0;
    end else if (advance_in) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/memory_arb.sv
// Multi-port round-robin front end to a single-port byte-strobed RAM.
// Define MEMORY_ARB_OUTREG_EN to add an output register (read latency 2).
module memory_arb
  import memory_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_SIZE  = 1024,
  parameter int ADDR_WIDTH = $clog2(DATA_SIZE),
  parameter int NUM_PORTS  = 2,
  parameter     PATH       = ""
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [NUM_PORTS-1:0]              req_valid_in,
  output logic [NUM_PORTS-1:0]              req_ready_out,
  input  logic [NUM_PORTS-1:0]              req_write_in,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_data_in,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_strb_in,
  output logic [NUM_PORTS-1:0]              rsp_valid_out,
  output logic [DATA_WIDTH-1:0]             rsp_data_out
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int IDX_W     = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] SIZE_L = (ADDR_WIDTH + 1)'(DATA_SIZE);

  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("memory_arb: DATA_WIDTH must be a multiple of 8");
  end
  if ((NUM_PORTS < 1) || (NUM_PORTS > MAX_PORTS)) begin : g_bad_ports
    $error("memory_arb: NUM_PORTS must be in 1..8");
  end
  if (ADDR_WIDTH < IDX_W) begin : g_bad_addr
    $error("memory_arb: ADDR_WIDTH too narrow for DATA_SIZE");
  end

  logic [DATA_WIDTH-1:0] mem_r [DATA_SIZE];

  logic [NUM_PORTS-1:0]  grant_s;
  logic                  transfer_s;
  logic                  sel_write_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [NUM_BYTES-1:0]  sel_strb_s;
  logic [IDX_W-1:0]      mem_idx_s;
  logic                  in_range_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic [NUM_PORTS-1:0]  rd_valid_r;
  logic [DATA_WIDTH-1:0] rd_data_r;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .valid_in   (req_valid_in),
    .advance_in (transfer_s),
    .grant_out  (grant_s)
  );

  assign req_ready_out = grant_s;
  assign transfer_s    = |grant_s;

  // The grant is one-hot, so an AND-OR mux selects the winning request fields.
  always_comb begin
    sel_write_s = 1'b0;
    sel_addr_s  = '0;
    sel_data_s  = '0;
    sel_strb_s  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_write_s = sel_write_s | (grant_s[i] & req_write_in[i]);
      sel_addr_s  = sel_addr_s | (req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_s[i]}});
      sel_data_s  = sel_data_s | (req_data_in[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_s[i]}});
      sel_strb_s  = sel_strb_s | (req_strb_in[i*NUM_BYTES +: NUM_BYTES] & {NUM_BYTES{grant_s[i]}});
    end
  end

  assign mem_idx_s  = sel_addr_s[IDX_W-1:0];
  assign in_range_s = ({1'b0, sel_addr_s} < SIZE_L);
  assign wr_en_s    = transfer_s & sel_write_s & in_range_s;
  assign rd_en_s    = transfer_s & ~sel_write_s;

  // Byte-strobed RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk_in) begin
    if (wr_en_s) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (sel_strb_s[b]) begin
          mem_r[mem_idx_s][b*8 +: 8] <= sel_data_s[b*8 +: 8];
        end
      end
    end
  end

  // Synchronous read stage; out-of-range reads load zero, idle cycles hold the data.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_valid_r <= '0;
      rd_data_r  <= '0;
    end else begin
      rd_valid_r <= grant_s & {NUM_PORTS{~sel_write_s}};
      if (rd_en_s && in_range_s) begin
        rd_data_r <= mem_r[mem_idx_s];
      end else if (rd_en_s) begin
        rd_data_r <= '0;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

`ifdef MEMORY_ARB_OUTREG_EN
  logic [NUM_PORTS-1:0]  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;

  // Extra output register stage; data only moves with a valid response.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_valid_r <= '0;
      out_data_r  <= '0;
    end else begin
      out_valid_r <= rd_valid_r;
      if (|rd_valid_r) begin
        out_data_r <= rd_data_r;
      end else begin
        out_data_r <= out_data_r;
      end
    end
  end

  assign rsp_valid_out = out_valid_r;
  assign rsp_data_out  = out_data_r;
`else
  assign rsp_valid_out = rd_valid_r;
  assign rsp_data_out  = rd_data_r;
`endif

endmodule

// File: tb/tb_memory_arb.sv
// Randomized and directed self-checking bench for memory_arb against a
// transaction-level model (round-robin by modulo scan, word array, response queue).
module tb_memory_arb;
  import memory_arb_pkg::*;

  localparam int DW = 32;
  localparam int DS = 1024;
  localparam int AW = 11;
  localparam int NP = 3;
  localparam int NB = DW / 8;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [NP-1:0]     req_valid_in;
  logic [NP-1:0]     req_ready_out;
  logic [NP-1:0]     req_write_in;
  logic [NP*AW-1:0]  req_addr_in;
  logic [NP*DW-1:0]  req_data_in;
  logic [NP*NB-1:0]  req_strb_in;
  logic [NP-1:0]     rsp_valid_out;
  logic [DW-1:0]     rsp_data_out;

  memory_arb #(
    .DATA_WIDTH (DW),
    .DATA_SIZE  (DS),
    .ADDR_WIDTH (AW),
    .NUM_PORTS  (NP),
    .PATH       ("")
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_write_in  (req_write_in),
    .req_addr_in   (req_addr_in),
    .req_data_in   (req_data_in),
    .req_strb_in   (req_strb_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_data_out  (rsp_data_out)
  );

  always #5 clk_in = ~clk_in;

  // Pending request held by each requestor
  logic          pv [NP];
  logic          pw [NP];
  logic [AW-1:0] pa [NP];
  logic [DW-1:0] pd [NP];
  logic [NB-1:0] ps [NP];

  // Reference model state
  logic [DW-1:0] mem_m [DS];
  int            ptr_m;
  int            cyc;
  logic [DW-1:0] last_m;
  typedef struct { int cyc; int port; logic [DW-1:0] data; } rsp_t;
  rsp_t          rq [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      req_valid_in[i]          = pv[i];
      req_write_in[i]          = pw[i];
      req_addr_in[i*AW +: AW]  = pa[i];
      req_data_in[i*DW +: DW]  = pd[i];
      req_strb_in[i*NB +: NB]  = ps[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NP; i++) begin
      pv[i] = 1'b0; pw[i] = 1'b0; pa[i] = '0; pd[i] = '0; ps[i] = '0;
    end
  endtask

  // One clock cycle: drive, check against the model, then advance the model at the edge.
  task automatic cycle();
    int            g;
    int            idx;
    logic [NP-1:0] exp_ready;
    logic [NP-1:0] exp_rv;
    drive();
    #1;
    g = -1;
    for (int k = 0; k < NP; k++) begin
      idx = (ptr_m + k) % NP;
      if (g < 0 && pv[idx]) g = idx;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    n_checks++;
    if (req_ready_out !== exp_ready) begin
      n_fail++;
      $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready_out, exp_ready);
    end
    exp_rv = '0;
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      exp_rv[rq[0].port] = 1'b1;
      last_m = rq[0].data;
      void'(rq.pop_front());
    end
    n_checks++;
    if (rsp_valid_out !== exp_rv) begin
      n_fail++;
      $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid_out, exp_rv);
    end
    n_checks++;
    if (rsp_data_out !== last_m) begin
      n_fail++;
      $display("FAIL rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data_out, last_m);
    end
    @(posedge clk_in);
    if (g >= 0) begin
      if (pw[g]) begin
        if (int'(pa[g]) < DS) begin
          for (int b = 0; b < NB; b++)
            if (ps[g][b]) mem_m[pa[g][9:0]][b*8 +: 8] = pd[g][b*8 +: 8];
        end
      end else begin
        rq.push_back('{cyc + RD_LATENCY, g, (int'(pa[g]) < DS) ? mem_m[pa[g][9:0]] : '0});
      end
      ptr_m = (g + 1) % NP;
      pv[g] = 1'b0;
    end
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic drain();
    clear_reqs();
    for (int i = 0; i < RD_LATENCY + 2; i++) cycle();
    n_checks++;
    if (rq.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d exp=0", rq.size());
    end
  endtask

  task automatic single_req(input int p, input logic w, input int a,
                            input logic [DW-1:0] d, input logic [NB-1:0] s);
    int budget;
    pv[p] = 1'b1; pw[p] = w; pa[p] = AW'(a); pd[p] = d; ps[p] = s;
    budget = 10;
    while (pv[p] && budget > 0) begin
      cycle();
      budget--;
    end
    n_checks++;
    if (pv[p]) begin
      n_fail++;
      $display("FAIL grant_timeout port=%0d got=pending exp=granted", p);
      pv[p] = 1'b0;
    end
  endtask

  task automatic model_reset();
    ptr_m  = 0;
    last_m = '0;
    rq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (req_ready_out !== '0 || rsp_valid_out !== '0 || rsp_data_out !== '0) begin
      n_fail++;
      $display("FAIL %s got ready=%b rv=%b data=%h exp all zero", tag, req_ready_out, rsp_valid_out, rsp_data_out);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    clear_reqs();
    for (int i = 0; i < NP; i++) pv[i] = 1'b1;
    drive();
    #1;
    check_reset_outputs("reset_state");
    repeat (2) @(negedge clk_in);
    check_reset_outputs("reset_held");
    rst_in = 1'b0;
    clear_reqs();
    model_reset();
    cyc = 0;
  endtask

  task automatic test_fill();
    for (int a = 0; a < 16; a++)
      single_req($urandom_range(0, NP - 1), 1'b1, a, $urandom, 4'hF);
    drain();
  endtask

  task automatic test_round_robin();
    for (int n = 0; n < 8; n++) begin
      pv[0] = 1'b1; pw[0] = 1'b0; pa[0] = AW'($urandom_range(0, 15));
      pv[1] = 1'b1; pw[1] = 1'b0; pa[1] = AW'($urandom_range(0, 15));
      cycle();
    end
    drain();
  endtask

  task automatic test_strobe();
    single_req(0, 1'b1, 5, 32'hAABBCCDD, 4'hF);
    single_req(0, 1'b1, 5, 32'h11223344, 4'h5);
    single_req(0, 1'b0, 5, 32'h0, 4'h0);
    drain();
    n_checks++;
    if (rsp_data_out !== 32'hAA22CC44) begin
      n_fail++;
      $display("FAIL strobe_merge got=%h exp=%h", rsp_data_out, 32'hAA22CC44);
    end
  endtask

  task automatic test_out_of_range();
    single_req(1, 1'b1, DS, 32'hDEADBEEF, 4'hF);
    single_req(1, 1'b0, DS, 32'h0, 4'h0);
    drain();
    n_checks++;
    if (rsp_data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL oob_read got=%h exp=%h", rsp_data_out, 32'h0);
    end
    for (int a = 0; a < 16; a++) single_req(2, 1'b0, a, 32'h0, 4'h0);
    drain();
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 4; n++) single_req(1, 1'b0, n, 32'h0, 4'h0);
    pv[0] = 1'b1; pw[0] = 1'b0; pa[0] = AW'(7);
    pv[1] = 1'b1; pw[1] = 1'b0; pa[1] = AW'(8);
    drive();
    #1;
    n_checks++;
    if (req_ready_out !== 3'b001) begin
      n_fail++;
      $display("FAIL wrap_grant got=%b exp=%b", req_ready_out, 3'b001);
    end
    cycle();
    cycle();
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NP; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1'b1;
          pw[i] = ($urandom_range(0, 2) == 0);
          pa[i] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DS, 2 * DS - 1))
                                              : AW'($urandom_range(0, 15));
          pd[i] = $urandom;
          ps[i] = NB'($urandom_range(0, 15));
        end
      end
      cycle();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 12; n++) begin
      pv[n % NP] = 1'b1; pw[n % NP] = 1'b0; pa[n % NP] = AW'($urandom_range(0, 15));
      cycle();
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    clear_reqs();
    pv[0] = 1'b1; pw[0] = 1'b0; pa[0] = AW'(5);
    drive();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    clear_reqs();
    drive();
    #1;
    check_reset_outputs("inflight_reset");
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    for (int n = 0; n < 4; n++) begin
      pv[0] = 1'b1; pw[0] = 1'b1; pa[0] = AW'(20); pd[0] = $urandom; ps[0] = 4'h0;
      pv[1] = 1'b1; pw[1] = 1'b1; pa[1] = AW'(21); pd[1] = $urandom; ps[1] = 4'h0;
      cycle();
    end
    drain();
  endtask

  initial begin
    cyc = 0;
    model_reset();
    test_reset();
    test_fill();
    test_round_robin();
    test_strobe();
    test_wrap();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
